// File: rtl/lab1_sweep_ctrl.sv
// Sweep sequencer for the lab 1 combinational unit: walks x through 0..7,
// samples z after a settle time and checks each response against a golden table.
module lab1_sweep_ctrl #(
    parameter int          SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'hEE13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  dut_z,
    output logic [2:0]  dut_x,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result,
    output logic [3:0]  err_cnt,
    output logic [2:0]  fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic [3:0] bit_idx;
    logic [1:0] exp_z;
    logic       mismatch;
    logic       last_code;

    assign bit_idx   = {dut_x, 1'b0};
    assign exp_z     = EXPECTED[bit_idx +: 2];
    assign mismatch  = (dut_z != exp_z);
    assign last_code = (dut_x == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort outranks start and every in-sweep transition
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_code) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_SETTLE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // busy/done are registered copies of the next state so they carry no input-to-output path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_x      <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            result     <= 16'h0000;
            err_cnt    <= 4'd0;
            fail_idx   <= 3'd0;
            settle_cnt <= 4'd0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        dut_x      <= 3'd0;
                        settle_cnt <= 4'd0;
                        result     <= 16'h0000;
                        err_cnt    <= 4'd0;
                        fail_idx   <= 3'd0;
                        pass       <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        dut_x      <= 3'd0;
                        settle_cnt <= 4'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        dut_x <= 3'd0;
                    end else begin
                        result[bit_idx +: 2] <= dut_z;
                        if (mismatch) begin
                            err_cnt <= err_cnt + 4'd1;
                            if (err_cnt == 4'd0) begin
                                fail_idx <= dut_x;
                            end
                        end
                        // pass is settled here so it is valid alongside the done pulse
                        if (last_code) begin
                            pass <= (err_cnt == 4'd0) && !mismatch;
                        end else begin
                            dut_x      <= dut_x + 3'd1;
                            settle_cnt <= 4'd0;
                        end
                    end
                end
                S_DONE: begin
                    dut_x <= 3'd0;
                    if (abort) begin
                        pass <= 1'b0;
                    end
                end
                default: begin
                    dut_x <= 3'd0;
                end
            endcase
        end
    end

endmodule
